// File: rtl/result_bcd_converter.sv
// result_bcd_converter: serial double-dabble converter from a 16-bit magnitude
// plus sign flag to five BCD digits, with valid/ready handshakes on both sides.
// One result takes 16 CONVERT cycles. A result is accepted in IDLE and then
// held in DONE until the display driver takes it.
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits above the units
// digit are shown as the blank code 4'hF.
module result_bcd_converter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic        in_neg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] bcd,
  output logic        out_neg,
  output logic        busy
);

  localparam int unsigned BIN_W  = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic [STEP_W-1:0]  step_q;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   dab_q, dab_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   final_d;
  logic               neg_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               out_neg_q;

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, binary} left
  always_comb begin
    adj = dab_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = 4'(adj[4*i +: 4] + 4'd3);
      end
    end
    {dab_d, bin_d} = (BCD_W + BIN_W)'({adj, bin_q} << 1);
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;

  // Replace leading zero digits above the units digit with the blank code
  always_comb begin
    final_d = dab_d;
    lead    = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (final_d[4*i +: 4] == 4'd0)) begin
        final_d[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  // Plain zero-padded BCD
  always_comb begin
    final_d = dab_d;
  end
`endif

  // Control FSM with capture, conversion datapath and registered results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      bin_q     <= '0;
      dab_q     <= '0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
      out_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q   <= in_result;
            neg_q   <= in_neg;
            dab_q   <= '0;
            step_q  <= '0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bin_q  <= bin_d;
          dab_q  <= dab_d;
          step_q <= STEP_W'(step_q + STEP_W'(1));
          if (step_q == STEP_W'(15)) begin
            bcd_q     <= final_d;
            out_neg_q <= neg_q;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and status flags decode directly from the state register
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign bcd       = bcd_q;
  assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Testbench for result_bcd_converter: directed vectors plus a random sweep.
// Stimulus pushes the expected digits into a queue at accept time, and a
// monitor pops and compares them on each output handshake.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_neg;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] bcd;
  logic        out_neg;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  logic        prev_hold = 1'b0;
  logic        prev_ov   = 1'b0;
  logic [19:0] prev_bcd  = '0;
  logic        prev_neg  = 1'b0;

  result_bcd_converter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .out_neg   (out_neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Pick the expected constant for the active build
  function automatic logic [19:0] pick(input logic [19:0] plain, input logic [19:0] blank);
`ifdef LEADING_ZERO_BLANK_EN
    return blank;
`else
    return plain;
`endif
  endfunction

  // Reference model: decimal digits by division, then optional blanking
  function automatic logic [19:0] model(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int d = 4; d >= 1; d--) begin
      if (r[4*d +: 4] != 4'd0) break;
      r[4*d +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic logic digits_legal(input logic [19:0] b);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < 5; d++) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (b[4*d +: 4] > 4'd9 && !(d > 0 && b[4*d +: 4] == 4'hF)) ok = 1'b0;
`else
      if (b[4*d +: 4] > 4'd9) ok = 1'b0;
`endif
    end
    return ok;
  endfunction

  // Monitor: latency, hold stability and scoreboard compare on handshakes
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_hold = 1'b0;
      prev_ov   = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      check("busy_vs_ready", 32'(busy), 32'(!in_ready));
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_bcd", 32'(bcd), 32'(prev_bcd));
        check("hold_neg", 32'(out_neg), 32'(prev_neg));
      end
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          check("latency", 32'(cyc - acc_q.pop_front()), 32'd17);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(bcd), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("bcd", 32'(bcd), 32'(e.bcd));
          check("out_neg", 32'(out_neg), 32'(e.neg));
          check("digits_legal", 32'(digits_legal(bcd)), 32'd1);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_ov   = out_valid;
      prev_bcd  = bcd;
      prev_neg  = out_neg;
    end
  end

  // Offer one value; returns the cycle stamp of the accepting negedge
  task automatic send(input logic [15:0] v, input logic n, input logic [19:0] e,
                      input bit keep, output int acc_cyc);
    int w;
    @(negedge clk);
    in_valid  = 1'b1;
    in_result = v;
    in_neg    = n;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    acc_cyc = cyc;
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{bcd: e, neg: n});
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !in_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0 || !in_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] v;
    logic        n;
    logic [19:0] e;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   a7, a8, a_tmp, w;
    logic [15:0] rv;
    logic        rn;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_neg    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_out_neg", 32'(out_neg), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed values with hand-computed digits
    vecs.push_back('{16'd0,     1'b0, pick(20'h00000, 20'hFFFF0)});
    vecs.push_back('{16'd65535, 1'b0, pick(20'h65535, 20'h65535)});
    vecs.push_back('{16'd1234,  1'b1, pick(20'h01234, 20'hF1234)});
    vecs.push_back('{16'd0,     1'b1, pick(20'h00000, 20'hFFFF0)});
    vecs.push_back('{16'd10,    1'b0, pick(20'h00010, 20'hFFF10)});
    vecs.push_back('{16'd9999,  1'b0, pick(20'h09999, 20'hF9999)});
    vecs.push_back('{16'd10000, 1'b1, pick(20'h10000, 20'h10000)});
    vecs.push_back('{16'd59999, 1'b0, pick(20'h59999, 20'h59999)});
    foreach (vecs[i]) begin
      send(vecs[i].v, vecs[i].n, vecs[i].e, 1'b0, a_tmp);
      wait_idle();
    end

    // Output held while the display driver stalls
    out_ready = 1'b0;
    send(16'd409, 1'b0, pick(20'h00409, 20'hFF409), 1'b0, a_tmp);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("hold_reached_done", 32'(out_valid), 32'd1);
    repeat (10) @(negedge clk);
    check("hold_still_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_idle", 32'(in_ready), 32'd1);
    check("hold_release_valid", 32'(out_valid), 32'd0);
    wait_idle();

    // in_valid held high across two values
    send(16'd7, 1'b0, pick(20'h00007, 20'hFFFF7), 1'b1, a7);
    send(16'd8, 1'b0, pick(20'h00008, 20'hFFFF8), 1'b0, a8);
    check("b2b_period", 32'(a8 - a7), 32'd18);
    wait_idle();

    // Reset during CONVERT step 8 drops the pending value
    send(16'd555, 1'b0, pick(20'h00555, 20'hFF555), 1'b0, a_tmp);
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    in_valid  = 1'b1;
    in_result = 16'd100;
    in_neg    = 1'b0;
    exp_q.push_back('{bcd: pick(20'h00100, 20'hFF100), neg: 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("first_edge_accept", 32'(busy), 32'd1);
    wait_idle();

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      rv = 16'($urandom_range(0, 65535));
      rn = 1'($urandom_range(0, 1));
      send(rv, rn, model(int'(rv)), 1'b0, a_tmp);
    end
    wait_idle();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 The module SHALL have port `clk`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port `in_valid`, input, 1 bit: upstream result present on `in_result`/`in_neg`.
REQ-004 The module SHALL have port `in_ready`, output, 1 bit: converter able to accept a result.
REQ-005 The module SHALL have port `in_result`, input, 16 bits: unsigned magnitude of the calculator result.
REQ-006 The module SHALL have port `in_neg`, input, 1 bit: sign flag accompanying `in_result`.
REQ-007 The module SHALL have port `out_valid`, output, 1 bit: converted digits present.
REQ-008 The module SHALL have port `out_ready`, input, 1 bit: downstream (display driver) accepts digits.
REQ-009 The module SHALL have port `bcd`, output, 20 bits: five BCD digits; [19:16] is ten-thousands, [3:0] is units.
REQ-010 The module SHALL have port `out_neg`, output, 1 bit: sign of the converted value.
REQ-011 The module SHALL have port `busy`, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONVERT, DONE.
REQ-013 `in_ready` SHALL be 1 only in IDLE; it SHALL be a pure decode of the state register.
REQ-014 IDLE -> CONVERT SHALL occur on the edge where `in_valid` and `in_ready` are both 1; `in_result` and `in_neg` SHALL be captured into internal registers on that edge, and the BCD shift register SHALL be cleared.
REQ-015 CONVERT SHALL last exactly 16 cycles, tracked by a 4-bit step counter that runs 0..15.
REQ-016 Each CONVERT cycle SHALL run one double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd, binary} left by one.
REQ-017 CONVERT -> DONE SHALL occur when the step counter equals 15; `bcd`/`out_neg` SHALL be updated on that same edge.
REQ-018 `out_valid` SHALL be 1 exactly in DONE; the latency from the accept edge to the first cycle with `out_valid` high SHALL be 17 cycles.
REQ-019 DONE -> IDLE SHALL occur on the edge where `out_valid` and `out_ready` are both 1; while `out_ready` is 0, `bcd` and `out_neg` SHALL hold stable.
REQ-020 `bcd`/`out_neg` SHALL retain the last delivered value until the next DONE.
REQ-021 `in_valid` during CONVERT or DONE SHALL be ignored; no result is lost because `in_ready` is 0.
REQ-022 Full range SHALL be supported: 0 -> 0x00000, 65535 -> 0x65535; every nibble SHALL be a legal BCD digit 0..9.
REQ-023 `out_neg` SHALL equal the captured `in_neg` unchanged, including when the magnitude is 0.
REQ-024 Back-to-back operation: after a DONE handshake the block SHALL be in IDLE for at least one cycle before the next accept, giving a minimum period of 18 cycles per result.

Reset
REQ-025 Assertion of `reset_n`=0 SHALL immediately force: state IDLE, step counter 0, `bcd`=0, `out_neg`=0, `out_valid`=0, `busy`=0, `in_ready`=1.
REQ-026 Reset asserted mid-CONVERT or in DONE SHALL abort the conversion and discard the pending result with no output.
REQ-027 After deassertion of `reset_n`, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-028 Macro `LEADING_ZERO_BLANK_EN` defined: in DONE, every leading zero digit above the units digit SHALL be replaced with 4'hF (blank code); the units digit SHALL never be blanked; all other behaviour SHALL be identical, including latency.
REQ-029 Macro `LEADING_ZERO_BLANK_EN` not defined: `bcd` SHALL carry plain zero-padded BCD.

Verification
REQ-030 Scenario: reset, then accept `in_result`=0, `in_neg`=0 with `out_ready`=1 -> `bcd`=0x00000 (0xFFFF0 with blank macro), `out_neg`=0, `out_valid` high 17 cycles after accept for 1 cycle.
REQ-031 Scenario: accept 65535 with `in_neg`=0 -> `bcd`=0x65535; accept 1234 with `in_neg`=1 -> `bcd`=0x01234 (0xF1234 with blank macro), `out_neg`=1.
REQ-032 Scenario: accept 409 with `out_ready` held 0 for 10 cycles after DONE -> `out_valid`, `bcd`=0x00409 stable throughout; return to IDLE one edge after `out_ready`=1.
REQ-033 Scenario: `in_valid` held high continuously with values 7, 8 -> exactly two results, 0x00007 then 0x00008, spaced 18 cycles apart; no value dropped or duplicated.
REQ-034 Scenario: `reset_n` pulsed low at CONVERT step 8 -> `out_valid` never rises for that value; `in_ready`=1 immediately; a following value 100 converts to 0x00100.
REQ-035 Scenario: random sweep of 1000 values checked against a reference model -> all digits <= 9 and the decimal value equals `in_result`.
